// File: rtl/timer_ch_sched.sv
// Multi-channel timer scheduler: one prescaled tick drives CH_NUM software timers
// through a single shared decrement/compare unit, scanned one channel per clock.
module timer_ch_sched #(
    parameter int unsigned CH_NUM    = 4,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned PTR_W     = $clog2(CH_NUM)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 tick_i,
    input  logic                 cfg_valid_i,
    input  logic [PTR_W-1:0]     cfg_ch_i,
    input  logic [CNT_WIDTH-1:0] cfg_period_i,
    input  logic                 cfg_en_i,
    input  logic                 cfg_periodic_i,
    input  logic [CH_NUM-1:0]    ien_i,
    input  logic [CH_NUM-1:0]    clr_i,
    input  logic                 ovr_clr_i,
    output logic [CH_NUM-1:0]    pend_o,
    output logic [CH_NUM-1:0]    en_o,
    output logic                 evt_valid_o,
    output logic [PTR_W-1:0]     evt_ch_o,
    output logic                 busy_o,
    output logic                 ovr_o,
    output logic                 irq_o
);

    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(CH_NUM - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t               state;
    logic [PTR_W-1:0]     ptr;
    logic [CNT_WIDTH-1:0] period [CH_NUM];
    logic [CNT_WIDTH-1:0] cnt    [CH_NUM];
    logic [CH_NUM-1:0]    en;
    logic [CH_NUM-1:0]    mode;
    logic [CH_NUM-1:0]    pend;
    logic                 ovr;

    logic                 cfg_hit;
    logic                 proc_act;
    logic                 expire;
    logic [CH_NUM-1:0]    set_vec;

    // A config write to the channel under the scan pointer suppresses processing.
    always_comb begin
        cfg_hit  = cfg_valid_i && (cfg_ch_i == ptr);
        proc_act = (state == SCAN) && en[ptr] && !cfg_hit;
        expire   = proc_act && (cnt[ptr] == '0);
        set_vec  = '0;
        if (expire) begin
            set_vec[ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            ptr         <= '0;
            en          <= '0;
            mode        <= '0;
            pend        <= '0;
            ovr         <= 1'b0;
            evt_valid_o <= 1'b0;
            evt_ch_o    <= '0;
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            evt_valid_o <= expire;
            evt_ch_o    <= expire ? ptr : '0;

            case (state)
                IDLE: begin
                    if (tick_i) begin
                        state <= SCAN;
                        ptr   <= '0;
                    end
                end
                SCAN: begin
                    if (ptr == LAST_CH) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + PTR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase

            if (ovr_clr_i) begin
                ovr <= 1'b0;
            end
            if (tick_i && (state == SCAN)) begin
                ovr <= 1'b1;
            end

            pend <= (pend & ~clr_i) | set_vec;

            if (proc_act) begin
                if (cnt[ptr] != '0) begin
                    cnt[ptr] <= cnt[ptr] - CNT_WIDTH'(1);
                end else if (mode[ptr]) begin
                    cnt[ptr] <= period[ptr];
                end else begin
                    en[ptr] <= 1'b0;
                end
            end

            if (cfg_valid_i) begin
                period[cfg_ch_i] <= cfg_period_i;
                cnt[cfg_ch_i]    <= cfg_period_i;
                en[cfg_ch_i]     <= cfg_en_i;
                mode[cfg_ch_i]   <= cfg_periodic_i;
            end
        end
    end

    assign pend_o = pend;
    assign en_o   = en;
    assign ovr_o  = ovr;
    assign busy_o = (state == SCAN);
    assign irq_o  = |(pend & ien_i);

endmodule
